// File: rtl/mandala_pkg.sv
// Shared types, constants and geometry helpers for the mandala layer engine.
// Mode encodings match the 2-bit mode request field.
package mandala_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE  = 2'd0,
    MODE_PULSE   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  localparam int PIPE_LAT     = 3;
  localparam int PAL_STEP     = 13;
  localparam int DEF_CENTER_X = 320;
  localparam int DEF_CENTER_Y = 240;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Octagonal distance approximation: max + min/2 always fits in 11 bits.
  function automatic logic [10:0] oct_radius(input logic [9:0] dx, input logic [9:0] dy);
    logic [9:0] hi;
    logic [9:0] lo;
    hi = (dx >= dy) ? dx : dy;
    lo = (dx >= dy) ? dy : dx;
    return {1'b0, hi} + 11'(lo >> 1);
  endfunction

endpackage

// File: rtl/mandala_layer_engine_if.sv
// Video-side bundle: pixel position/syncs in, colour and delayed syncs out.
// The source (timing generator or bench) is the master; the engine is the slave.
interface mandala_layer_engine_if #(
  parameter int COLOR_BITS = 2
);
  logic [9:0]            pix_x;
  logic [9:0]            pix_y;
  logic                  de_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  de_out;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;

  modport master (
    output pix_x, pix_y, de_in, hsync_in, vsync_in,
    input  hsync_out, vsync_out, de_out, r, g, b
  );

  modport slave (
    input  pix_x, pix_y, de_in, hsync_in, vsync_in,
    output hsync_out, vsync_out, de_out, r, g, b
  );
endinterface

// File: rtl/mandala_anim_ctrl.sv
// Frame-rate animation control: vsync tick, config shadowing, speed prescaler,
// pause/single-step and the free-running frame counter.
module mandala_anim_ctrl
  import mandala_pkg::*;
#(
  parameter int SPEED_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_in,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               step,
  output mode_t              mode_sh,
  output logic [7:0]         phase,
  output logic [15:0]        frame_cnt
);

  logic               vsync_prev_reg;
  logic               step_prev_reg;
  mode_t              mode_sh_reg,      mode_sh_next;
  logic [SPEED_W-1:0] speed_sh_reg,     speed_sh_next;
  logic               pause_sh_reg,     pause_sh_next;
  logic [SPEED_W-1:0] presc_reg,        presc_next;
  logic [7:0]         phase_reg,        phase_next;
  logic [15:0]        frame_cnt_reg,    frame_cnt_next;
  logic               step_pending_reg, step_pending_next;

  logic tick;
  logic step_edge;
  logic pause_eff;

  assign tick      = vsync_in & ~vsync_prev_reg;
  assign step_edge = step & ~step_prev_reg;
  // A tick that latches a new pause value obeys it immediately.
  assign pause_eff = tick ? pause : pause_sh_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_reg   <= 1'b0;
      step_prev_reg    <= 1'b0;
      mode_sh_reg      <= MODE_ROTATE;
      speed_sh_reg     <= '0;
      pause_sh_reg     <= 1'b0;
      presc_reg        <= '0;
      phase_reg        <= '0;
      frame_cnt_reg    <= '0;
      step_pending_reg <= 1'b0;
    end else begin
      vsync_prev_reg   <= vsync_in;
      step_prev_reg    <= step;
      mode_sh_reg      <= mode_sh_next;
      speed_sh_reg     <= speed_sh_next;
      pause_sh_reg     <= pause_sh_next;
      presc_reg        <= presc_next;
      phase_reg        <= phase_next;
      frame_cnt_reg    <= frame_cnt_next;
      step_pending_reg <= step_pending_next;
    end
  end

  always_comb begin
    mode_sh_next      = mode_sh_reg;
    speed_sh_next     = speed_sh_reg;
    pause_sh_next     = pause_sh_reg;
    presc_next        = presc_reg;
    phase_next        = phase_reg;
    frame_cnt_next    = frame_cnt_reg;
    step_pending_next = step_pending_reg;

    if (tick) begin
      mode_sh_next   = mode_t'(mode);
      speed_sh_next  = speed;
      pause_sh_next  = pause;
      frame_cnt_next = frame_cnt_reg + 16'd1;
      if (!pause_eff) begin
        step_pending_next = 1'b0;
        if (presc_reg == speed_sh_reg) begin
          presc_next = '0;
          phase_next = phase_reg + 8'd1;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end else if (step_pending_reg) begin
        phase_next        = phase_reg + 8'd1;
        step_pending_next = 1'b0;
      end
    end

    // An edge arriving with the tick survives it and waits for the next one.
    if (step_edge) begin
      step_pending_next = 1'b1;
    end
  end

  assign mode_sh   = mode_sh_reg;
  assign phase     = phase_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: rtl/mandala_layer_engine.sv
// Three-stage mandala pixel pipeline (distance, ring/angle, colour) with a
// matching sync delay line; animation state comes from mandala_anim_ctrl.
module mandala_layer_engine
  import mandala_pkg::*;
#(
  parameter int NUM_LAYERS = 7,
  parameter int RING_SHIFT = 5,
  parameter int COLOR_BITS = 2,
  parameter int CENTER_X   = DEF_CENTER_X,
  parameter int CENTER_Y   = DEF_CENTER_Y,
  parameter int SPEED_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mandala_layer_engine_if.slave  vid,
  input  logic [1:0]             mode,
  input  logic [SPEED_W-1:0]     speed,
  input  logic                   pause,
  input  logic                   step,
  output logic [15:0]            frame_cnt
);

  localparam int          CW         = 3 * COLOR_BITS;
  localparam logic [9:0]  CX         = 10'(CENTER_X);
  localparam logic [9:0]  CY         = 10'(CENTER_Y);
  localparam logic [10:0] RING_LIMIT = 11'(NUM_LAYERS);
  localparam logic [3:0]  NL4        = 4'(NUM_LAYERS);

  mode_t      mode_sh;
  logic [7:0] phase;

  mandala_anim_ctrl #(
    .SPEED_W (SPEED_W)
  ) u_anim (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_in  (vid.vsync_in),
    .mode      (mode),
    .speed     (speed),
    .pause     (pause),
    .step      (step),
    .mode_sh   (mode_sh),
    .phase     (phase),
    .frame_cnt (frame_cnt)
  );

  logic [9:0]    dx_s1, dy_s1;
  logic [10:0]   radius;
  logic [10:0]   ring_next;
  logic [7:0]    xr;
  logic [7:0]    ang_next;
  logic [10:0]   ring_s2;
  logic [7:0]    ang_s2;
  logic [7:0]    phase_s2;
  logic          chk_s2;
  logic [3:0]    pulse_ring;
  logic          mode_hit;
  logic          lit;
  logic          de_s2;
  logic [CW-1:0] colour_next;
  logic [CW-1:0] colour_reg;
  logic [2:0]    sync_d [PIPE_LAT];

  always_comb begin
    radius    = oct_radius(dx_s1, dy_s1);
    ring_next = radius >> RING_SHIFT;
    xr        = dx_s1[7:0] ^ dy_s1[7:0];
    // Odd and even rings spin in opposite directions.
    ang_next  = ring_next[0] ? (xr + phase) : (xr - phase);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_s1    <= '0;
      dy_s1    <= '0;
      ring_s2  <= '0;
      ang_s2   <= '0;
      phase_s2 <= '0;
      chk_s2   <= 1'b0;
    end else begin
      dx_s1    <= abs_diff(vid.pix_x, CX);
      dy_s1    <= abs_diff(vid.pix_y, CY);
      ring_s2  <= ring_next;
      ang_s2   <= ang_next;
      phase_s2 <= phase;
      chk_s2   <= dx_s1[4] ^ dy_s1[4];
    end
  end

  assign pulse_ring = phase_s2[7:4] % NL4;
  assign de_s2      = sync_d[PIPE_LAT-2][0];

  always_comb begin
    mode_hit = 1'b0;
    case (mode_sh)
      MODE_ROTATE:  mode_hit = 1'(ang_s2 >> 5) ^ ring_s2[0];
      MODE_PULSE:   mode_hit = (ring_s2[3:0] == pulse_ring);
      MODE_CHECKER: mode_hit = chk_s2 ^ phase_s2[3];
      MODE_SOLID:   mode_hit = 1'b1;
      default:      mode_hit = 1'b0;
    endcase
    lit = (ring_s2 < RING_LIMIT) && mode_hit;
    colour_next = '0;
    if (lit && de_s2) begin
      colour_next = CW'(phase_s2 >> 2) + CW'(32'(ring_s2) * PAL_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_reg <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_d[i] <= '0;
      end
    end else begin
      colour_reg <= colour_next;
      sync_d[0]  <= {vid.hsync_in, vid.vsync_in, vid.de_in};
      for (int i = 1; i < PIPE_LAT; i++) begin
        sync_d[i] <= sync_d[i-1];
      end
    end
  end

  assign vid.hsync_out = sync_d[PIPE_LAT-1][2];
  assign vid.vsync_out = sync_d[PIPE_LAT-1][1];
  assign vid.de_out    = sync_d[PIPE_LAT-1][0];
  assign vid.r         = colour_reg[CW-1 -: COLOR_BITS];
  assign vid.g         = colour_reg[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vid.b         = colour_reg[COLOR_BITS-1:0];

endmodule

// File: doc/mandala_layer_engine.md
Name: mandala_layer_engine

Overview:
Parametrised, pipelined mandala pixel generator; successor to the fixed 7-ring animated VGA pattern.
- Sits between hvsync_generator and the TinyTapeout uo_out mux: consumes pixel position/sync, emits colour plus matching-delayed syncs.
- Adds configurable ring count/width/colour depth, four render modes, a speed prescaler, pause/single-step, and frame-boundary config latching.

Parameters:
NUM_LAYERS, 7, number of lit rings (1..15)
RING_SHIFT, 5, ring width = 2^RING_SHIFT pixels of octagonal radius
COLOR_BITS, 2, bits per R/G/B channel (1..4)
CENTER_X, 320, pattern centre column
CENTER_Y, 240, pattern centre row
SPEED_W, 4, width of speed field

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_x  in  10  current column
pix_y  in  10  current row
de_in  in  1  display enable
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync (active-high pulse)
mode  in  2  render mode request
speed  in  SPEED_W  frames per phase step minus 1
pause  in  1  freeze animation
step  in  1  single-step request (level, edge-detected)
hsync_out  out  1  hsync delayed 3 cycles
vsync_out  out  1  vsync delayed 3 cycles
de_out  out  1  de delayed 3 cycles
r, g, b  out  COLOR_BITS each  pixel colour
frame_cnt  out  16  free-running frame counter

Behaviour:
- Reset: reset is rst_n, asynchronous, active-low; clock is clk. All outputs 0; phase=0, prescaler=0, frame_cnt=0, step_pending=0. Shadow config: mode=0, speed=0, pause=0. Pipeline stages cleared.
- Frame tick: single-cycle pulse on vsync_in rising edge, detected via registered vsync_prev (reset 0).
- Config latching:
  - mode, speed and pause are copied to shadow registers on the frame tick only.
  - Mid-frame changes are invisible until the next tick.
  - The tick that latches a new pause value also applies it in that same cycle.
- frame_cnt: +1 on every tick, regardless of pause; wraps 0xFFFF->0.
- Animation, evaluated on a tick:
  - Not paused: if presc==speed_sh, then presc<=0 and phase<=phase+1 (8-bit wrap 255->0); else presc<=presc+1. speed=0 advances phase every frame.
  - Paused: presc holds. If step_pending, phase+1 and step_pending cleared; else phase holds.
  - Ticks while not paused also clear step_pending.
- Step edge: a rising edge of step sets step_pending. An edge coinciding with a tick is not consumed by that tick; it stays pending for the next one.
- Pipeline, latency exactly 3 cycles, no stalls:
  - S1: dx=|pix_x-CENTER_X|, dy=|pix_y-CENTER_Y| (10-bit).
  - S2: radius = max(dx,dy) + (min(dx,dy)>>1), 11-bit, no overflow. ring = radius>>RING_SHIFT. ang = (dx[7:0]^dy[7:0]) + phase for odd rings, - phase for even rings (8-bit modular).
  - S3: lit decision and colour register.
- lit requires ring<NUM_LAYERS; the mode condition is then:
  - mode0 ROTATE: ang[5]^ring[0]
  - mode1 PULSE: ring[3:0]==(phase[7:4] mod NUM_LAYERS)
  - mode2 CHECKER: dx[4]^dy[4]^phase[3]
  - mode3 SOLID: 1
- Colour:
  - c = (phase[7:2] + ring*PAL_STEP) truncated to 3*COLOR_BITS.
  - {r,g,b} = c, r in MSBs.
  - Unlit pixels, or de_out=0: all zero.
- Centre pixel gives dx=dy=0, radius 0, ring 0 (lit per mode).
- Reset asserted mid-frame: immediate clear. The first tick after release starts a fresh prescaler count.

Decomposition:
- Package mandala_pkg: mode encodings (MODE_ROTATE=0, MODE_PULSE=1, MODE_CHECKER=2, MODE_SOLID=3), PIPE_LAT=3, PAL_STEP=13, default CENTER_X/CENTER_Y.
- Sub-module mandala_anim_ctrl: tick detect, config shadow, prescaler, pause/step, phase, frame_cnt.
- Top: datapath pipeline plus sync delay line.

Test Plan:
- Reset release, then hold vsync_in=0 for 1000 cycles -> all outputs 0, frame_cnt=0, phase=0.
- speed=2, pause=0, 9 vsync pulses -> phase=3, frame_cnt=9.
- Pixel (320,240), de_in=1, mode=3, phase=0 -> de_out=1 and rgb=0 exactly 3 cycles later; hsync/vsync/de_out each equal input delayed 3 cycles.
- Pixel (320+7*32,240)=(544,240), NUM_LAYERS=7 -> ring 7, output black in all modes. Pixel (352,240) in mode3 -> c=13 -> r=0,g=3,b=1.
- pause=1 latched, 3 step edges spread over 5 ticks -> phase +3, frame_cnt +5. Step edge on the same cycle as a tick -> phase advances on the following tick.
- mode changed 0->1 mid-frame -> output unchanged until after the next vsync rising edge. Reset asserted mid-line -> outputs 0 in the same cycle.
